// File: rtl/dds_pkg.sv
// dds_pkg: shared widths and FSM state type for the DAC SPI transmitter
// Provides DAC_W (sample width), FRAME_W (SPI word width), CTRL_W (control prefix width), spi_state_e.
package dds_pkg;
  localparam int DAC_W = 12;
  localparam int FRAME_W = 16;
  localparam int CTRL_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} spi_state_e;
endpackage

// File: rtl/sclk_div.sv
// sclk_div: free-running half-period tick generator for the SPI clock
// Ports: clk, rst (sync, active high), clr (restart count), tick (high in last cycle of each DIV-cycle window).
module sclk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [7:0] cnt_q, cnt_d;
  assign tick = cnt_q == 8'(DIV - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 8'd1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 12-bit samples with a 4-bit control prefix to an SPI DAC (mode 0, MSB first)
// Inputs: sys_clk, sys_rst (sync, active high), din/din_valid sample handshake.
// Outputs: din_ready, dac_cs_n/dac_sclk/dac_mosi SPI pins, busy, frame_done (one-cycle end-of-frame pulse).
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 2,
  parameter logic [CTRL_W-1:0] CTRL_BITS = 4'b0000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [DAC_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dac_cs_n,
  output logic             dac_sclk,
  output logic             dac_mosi,
  output logic             busy,
  output logic             frame_done
);
  spi_state_e state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] gap_q, gap_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, busy_q, busy_d, done_q, done_d;
  logic accept, tick;
  // Ready is held low during reset so nothing is accepted on the reset edge.
  assign din_ready = state_q == IDLE && !sys_rst;
  assign accept = din_valid && din_ready;
  sclk_div #(.DIV(CLK_DIV)) u_div (
    .clk(sys_clk),
    .rst(sys_rst),
    .clr(accept),
    .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bit_d = bit_q;
    gap_d = gap_q;
    cs_n_d = cs_n_q;
    sclk_d = sclk_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SHIFT;
        sr_d = {CTRL_BITS, din};
        bit_d = '0;
        cs_n_d = 1'b0;
        sclk_d = 1'b0;
      end
      SHIFT: if (tick) begin
        sclk_d = !sclk_q;
        // End of a high phase closes the bit; the zero fill leaves mosi low once all 16 bits are out.
        if (sclk_q) begin
          bit_d = bit_q + 4'd1;
          sr_d = {sr_q[FRAME_W-2:0], 1'b0};
          if (bit_q == 4'd15) begin
            state_d = GAP;
            cs_n_d = 1'b1;
            done_d = 1'b1;
            gap_d = '0;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        state_d = gap_q == 8'(CS_GAP - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_mosi = sr_q[FRAME_W-1];
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: randomized self-checking bench decoding the SPI pins of a default and a minimum-parameter DAC transmitter
module tb_dac_spi_tx;
  localparam int DA = 4, GA = 2, DB = 1, GB = 1;
  localparam logic [3:0] CA = 4'b0000, CB = 4'b1001;
  logic clk = 0, rst = 1;
  logic [11:0] din_a = 0, din_b = 0;
  logic val_a = 0, val_b = 0;
  logic rdy_a, cs_a, sclk_a, mosi_a, busy_a, done_a;
  logic rdy_b, cs_b, sclk_b, mosi_b, busy_b, done_b;
  int errs = 0, checks = 0, cyc = 0;
  logic [15:0] word[2], exp_w[2];
  bit exp_v[2];
  int low[2], bits[2], t_acc[2];
  int frames[2] = '{0, 0};
  logic pcs[2], psclk[2];

  dac_spi_tx #(.CLK_DIV(DA), .CS_GAP(GA), .CTRL_BITS(CA)) u_a (
    .sys_clk(clk), .sys_rst(rst), .din(din_a), .din_valid(val_a), .din_ready(rdy_a),
    .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a), .busy(busy_a), .frame_done(done_a));
  dac_spi_tx #(.CLK_DIV(DB), .CS_GAP(GB), .CTRL_BITS(CB)) u_b (
    .sys_clk(clk), .sys_rst(rst), .din(din_b), .din_valid(val_b), .din_ready(rdy_b),
    .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b), .busy(busy_b), .frame_done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int dv(input int i); return i != 0 ? DB : DA; endfunction
  function automatic int gv(input int i); return i != 0 ? GB : GA; endfunction
  function automatic logic [3:0] cv(input int i); return i != 0 ? CB : CA; endfunction
  function automatic logic rdy(input int i); return i != 0 ? rdy_b : rdy_a; endfunction

  // Decodes the SPI pins: words captured on SCLK rising edges while CS is low, checked when CS rises.
  task automatic mon(input int i, input logic cs, input logic sc, input logic mo, input logic dn, input logic rd, input logic bz);
    if (rst) begin
      check("rst_cs_n", cs, 1);
      check("rst_sclk", sc, 0);
      check("rst_mosi", mo, 0);
      check("rst_done", dn, 0);
      check("rst_ready", rd, 0);
      check("rst_busy", bz, 0);
      exp_v[i] = 0; low[i] = 0; bits[i] = 0; word[i] = 0; pcs[i] = 1; psclk[i] = 0;
    end else begin
      if (!cs) begin
        low[i]++;
        check("busy_in_frame", bz, 1);
        check("ready_in_frame", rd, 0);
        check("done_in_frame", dn, 0);
        if (sc && !psclk[i]) begin
          word[i] = {word[i][14:0], mo};
          bits[i]++;
        end
      end else begin
        check("idle_sclk", sc, 0);
        check("idle_mosi", mo, 0);
        if (!pcs[i]) begin
          check("frame_done", dn, 1);
          check("word", word[i], exp_w[i]);
          check("bits", bits[i], 16);
          check("cs_low_cycles", low[i], 32 * dv(i));
          check("expected_pending", exp_v[i], 1);
          check("busy_gap", bz, 1);
          exp_v[i] = 0;
          frames[i]++;
        end else check("done_idle", dn, 0);
        low[i] = 0; bits[i] = 0; word[i] = 0;
      end
      pcs[i] = cs; psclk[i] = sc;
    end
  endtask

  always @(negedge clk) begin
    mon(0, cs_a, sclk_a, mosi_a, done_a, rdy_a, busy_a);
    mon(1, cs_b, sclk_b, mosi_b, done_b, rdy_b, busy_b);
  end

  task automatic accept(input int i, input logic [11:0] d);
    int n = 0;
    if (i == 0) begin din_a = d; val_a = 1; end else begin din_b = d; val_b = 1; end
    while (!rdy(i) && n < 1000) begin @(negedge clk); n++; end
    check("accept_wait", 32'(n < 1000), 1);
    t_acc[i] = cyc;
    exp_w[i] = {cv(i), d};
    exp_v[i] = 1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rdy(i) && n < 1000);
    check("ready_latency", 32'(cyc - t_acc[i]), 32'(1 + 32 * dv(i) + gv(i)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, r, n;
    logic p;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    // single frame; din scrambled after acceptance
    accept(0, 12'hA5C);
    @(negedge clk);
    val_a = 0;
    din_a = 12'($urandom);
    wait_ready(0);
    // back-to-back with valid held high
    accept(0, 12'h000);
    @(negedge clk);
    din_a = 12'hFFF;
    wait_ready(0);
    accept(0, 12'hFFF);
    @(negedge clk);
    din_a = 12'h800;
    wait_ready(0);
    accept(0, 12'h800);
    @(negedge clk);
    val_a = 0;
    wait_ready(0);
    // new sample offered while busy must be ignored
    accept(0, 12'h123);
    @(negedge clk);
    val_a = 0;
    repeat (10) @(negedge clk);
    din_a = 12'h456;
    val_a = 1;
    repeat (80) @(negedge clk);
    val_a = 0;
    wait_ready(0);
    f0 = frames[0];
    repeat (200) @(negedge clk);
    check("no_second_frame", frames[0], f0);
    check("idle_busy", busy_a, 0);
    // reset after the fifth SCLK rising edge
    accept(0, 12'($urandom));
    @(negedge clk);
    val_a = 0;
    r = 0; n = 0; p = 0;
    while (r < 5 && n < 2000) begin
      @(negedge clk);
      n++;
      if (sclk_a && !p) r++;
      p = sclk_a;
    end
    check("five_rises_seen", r, 5);
    f0 = frames[0];
    #1 rst = 1;
    @(negedge clk);
    #1 rst = 0;
    #1 check("ready_after_rst", rdy_a, 1);
    check("abort_no_frame", frames[0], f0);
    accept(0, 12'h3C3);
    @(negedge clk);
    val_a = 0;
    wait_ready(0);
    // randomized frames with noise offered while busy
    for (int k = 0; k < 8; k++) begin
      accept(0, 12'($urandom));
      @(negedge clk);
      din_a = 12'($urandom);
      val_a = 1'($urandom_range(0, 1));
      repeat (30) @(negedge clk);
      val_a = 0;
      wait_ready(0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    // minimum-parameter instance
    accept(1, 12'h001);
    @(negedge clk);
    val_b = 0;
    wait_ready(1);
    for (int k = 0; k < 4; k++) begin
      accept(1, 12'($urandom));
      @(negedge clk);
      din_b = 12'($urandom);
      val_b = 1'($urandom_range(0, 1));
      repeat (5) @(negedge clk);
      val_b = 0;
      wait_ready(1);
    end
    repeat (5) @(negedge clk);
    check("frames_a", frames[0], 14);
    check("frames_b", frames[1], 5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
